// File: rtl/shift_subtract_divider_if.sv
// ---------------------------------------------------------------------------
// shift_subtract_divider_if
// Handshake and operand/result bundle for the sequential divider.
//   start         request from the controller, honoured only while ready=1
//   inp_Dividend  dividend, captured on the accepted start edge
//   inp_Divisor   divisor, captured on the accepted start edge
//   ready         divider can take a new start (IDLE or DONE)
//   done          one-cycle strobe, results valid from this cycle
//   div_by_zero   current result came from a zero divisor
//   out_Quotient  registered quotient
//   out_Remainder registered remainder
// master: the controller side; slave: the divider.
// ---------------------------------------------------------------------------
interface shift_subtract_divider_if #(
  parameter int NBits = 16
);
  logic             start;
  logic [NBits-1:0] inp_Dividend;
  logic [NBits-1:0] inp_Divisor;
  logic             ready;
  logic             done;
  logic             div_by_zero;
  logic [NBits-1:0] out_Quotient;
  logic [NBits-1:0] out_Remainder;

  modport master (
    output start, inp_Dividend, inp_Divisor,
    input  ready, done, div_by_zero, out_Quotient, out_Remainder
  );

  modport slave (
    input  start, inp_Dividend, inp_Divisor,
    output ready, done, div_by_zero, out_Quotient, out_Remainder
  );
endinterface

// File: rtl/shift_subtract_divider.sv
// ---------------------------------------------------------------------------
// shift_subtract_divider
// Sequential restoring divider: one quotient bit per clock by shifting
// {R,Q} left and trial-subtracting the divisor. A nonzero division takes
// NBits cycles from the accepted start edge to the done strobe; a zero
// divisor finishes straight away with quotient all-ones and remainder equal
// to the dividend.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   shift_subtract_divider_if.slave (start/operands in, results out)
//
// Optional build macro
//   DIVIDER_SIGNED_EN  two's complement operands/results, truncating
//                      toward zero. Undefined: unsigned only.
// ---------------------------------------------------------------------------
module shift_subtract_divider #(
  parameter int NBits = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  shift_subtract_divider_if.slave  bus
);

  localparam int CntW = $clog2(NBits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [NBits:0]   rem_q;
  logic [NBits-1:0] quo_q;
  logic [NBits-1:0] dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             ready_q;
  logic             done_q;
  logic             dbz_q;
  logic [NBits-1:0] outQuo_q;
  logic [NBits-1:0] outRem_q;
`ifdef DIVIDER_SIGNED_EN
  logic             negQuo_q;
  logic             negRem_q;
`endif

  logic [NBits:0]   remShift;
  logic [NBits:0]   trial;
  logic [NBits:0]   rem_d;
  logic [NBits-1:0] quo_d;
  logic [NBits-1:0] dividendMag;
  logic [NBits-1:0] divisorMag;
  logic [NBits-1:0] finalQuo;
  logic [NBits-1:0] finalRem;
  logic             divisorZero;

  // The partial remainder always stays below the divisor, so its top bit is
  // only ever needed inside the trial subtraction and never read back.
  logic unusedRemMsb;
  assign unusedRemMsb = rem_q[NBits];

  assign divisorZero = (bus.inp_Divisor == '0);

  // One restoring step: shift {R,Q} left, try R - D, keep it if it did not
  // borrow (trial MSB clear) and record the quotient bit.
  always_comb begin
    remShift = {rem_q[NBits-1:0], quo_q[NBits-1]};
    trial    = remShift - {1'b0, dvs_q};
    rem_d    = remShift;
    quo_d    = {quo_q[NBits-2:0], 1'b0};
    if (!trial[NBits]) begin
      rem_d = trial;
      quo_d = {quo_q[NBits-2:0], 1'b1};
    end
  end

`ifdef DIVIDER_SIGNED_EN
  // Divide magnitudes; the most-negative value maps onto itself, which reads
  // correctly as an unsigned magnitude. Signs are reapplied on DONE entry.
  always_comb begin
    dividendMag = bus.inp_Dividend[NBits-1] ? -bus.inp_Dividend : bus.inp_Dividend;
    divisorMag  = bus.inp_Divisor[NBits-1]  ? -bus.inp_Divisor  : bus.inp_Divisor;
    finalQuo    = negQuo_q ? -quo_d : quo_d;
    finalRem    = negRem_q ? -rem_d[NBits-1:0] : rem_d[NBits-1:0];
  end
`else
  always_comb begin
    dividendMag = bus.inp_Dividend;
    divisorMag  = bus.inp_Divisor;
    finalQuo    = quo_d;
    finalRem    = rem_d[NBits-1:0];
  end
`endif

  // Control FSM and all registered state. done is a strobe that is only
  // raised on the edge that enters DONE, so it falls on its own next cycle
  // unless another zero-divisor start re-enters DONE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      outQuo_q <= '0;
      outRem_q <= '0;
`ifdef DIVIDER_SIGNED_EN
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            dbz_q <= divisorZero;
            if (divisorZero) begin
              state_q  <= DONE;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
              outQuo_q <= '1;
              outRem_q <= bus.inp_Dividend;
            end else begin
              state_q <= RUN;
              ready_q <= 1'b0;
              rem_q   <= '0;
              quo_q   <= dividendMag;
              dvs_q   <= divisorMag;
              cnt_q   <= CntW'(NBits);
`ifdef DIVIDER_SIGNED_EN
              negQuo_q <= bus.inp_Dividend[NBits-1] ^ bus.inp_Divisor[NBits-1];
              negRem_q <= bus.inp_Dividend[NBits-1];
`endif
            end
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end

        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CntW'(1);
          // Last iteration: publish the finished result on the same edge.
          if (cnt_q == CntW'(1)) begin
            state_q  <= DONE;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            outQuo_q <= finalQuo;
            outRem_q <= finalRem;
          end
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready         = ready_q;
  assign bus.done          = done_q;
  assign bus.div_by_zero   = dbz_q;
  assign bus.out_Quotient  = outQuo_q;
  assign bus.out_Remainder = outRem_q;

endmodule
